lcd_row_driver: RTL and testbench

LCD_ROW_DRIVER -- requirements
Module: lcd_row_driver

---
 rtl/lcd_row_driver.sv | 226 ++++++++++++++++++++++
 tb/tb_lcd_row_driver.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_row_driver.sv
// lcd_row_driver
// Continuously refreshes a 16x2 HD44780-style character LCD over its 8-bit
// parallel bus. After reset it waits out the panel power-up time, then runs
// the init sequence (function set, display on, entry mode, clear). After that
// it streams frames forever: set DDRAM address to the top row, 16 top
// characters, set address to the bottom row, 16 bottom characters.
// Every byte transfer is three equal phases: setup (EN low), strobe (EN high)
// and hold (EN low), with RS/DATA held for the whole transfer.
//
// Ports
//   clk         system clock
//   nRst        asynchronous active-low reset
//   row_top     upper row text, 16 ASCII chars, [127:120] leftmost
//   row_bottom  lower row text, same byte order
//   lcd_en      enable strobe
//   lcd_rs      register select (0 command, 1 data)
//   lcd_rw      read/write select, always write (0)
//   lcd_data    8-bit data bus
//   init_done   high from the end of the init sequence until reset
//   frame_done  one-cycle pulse in the last cycle of every full refresh
module lcd_row_driver #(
    parameter int PHASE_CYCLES   = 6000,
    parameter int POWERUP_CYCLES = 240000,
    parameter int CLEAR_CYCLES   = 24000
) (
    input  logic         clk,
    input  logic         nRst,
    input  logic [127:0] row_top,
    input  logic [127:0] row_bottom,
    output logic         lcd_en,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic [7:0]   lcd_data,
    output logic         init_done,
    output logic         frame_done
);

    localparam int MAX_AB = (PHASE_CYCLES > CLEAR_CYCLES) ? PHASE_CYCLES : CLEAR_CYCLES;
    localparam int MAX_CNT = (POWERUP_CYCLES > MAX_AB) ? POWERUP_CYCLES : MAX_AB;
    localparam int CW = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CW-1:0] PH_LAST  = CW'(PHASE_CYCLES - 1);
    localparam logic [CW-1:0] PU_LAST  = CW'(POWERUP_CYCLES - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_CYCLES - 1);

    localparam logic [2:0] ST_POWERUP   = 3'd0;
    localparam logic [2:0] ST_INIT      = 3'd1;
    localparam logic [2:0] ST_ADDR_TOP  = 3'd2;
    localparam logic [2:0] ST_WRITE_TOP = 3'd3;
    localparam logic [2:0] ST_ADDR_BOT  = 3'd4;
    localparam logic [2:0] ST_WRITE_BOT = 3'd5;

    localparam logic [1:0] PH_A = 2'd0;
    localparam logic [1:0] PH_B = 2'd1;
    localparam logic [1:0] PH_C = 2'd2;

    // init_idx 0..3 selects the init command; 4 is the post-clear wait.
    localparam logic [2:0] CLR_WAIT = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [1:0]    phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    idx_q, idx_d;
    logic [2:0]    init_idx_q, init_idx_d;
    logic [127:0]  snap_top_q, snap_top_d;
    logic [127:0]  snap_bot_q, snap_bot_d;
    logic          lcd_en_q, lcd_en_d;
    logic          lcd_rs_q, lcd_rs_d;
    logic [7:0]    lcd_data_q, lcd_data_d;
    logic          init_done_q, init_done_d;
    logic          frame_done_q, frame_done_d;

    logic          in_xfer;
    logic          xfer_end;
    logic          xfer_next;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        init_idx_d = init_idx_q;
        snap_top_d = snap_top_q;
        snap_bot_d = snap_bot_q;
        xfer_end   = 1'b0;

        // Shared phase sequencer for every state that is moving a byte.
        in_xfer = (state_q != ST_POWERUP) &&
                  !((state_q == ST_INIT) && (init_idx_q == CLR_WAIT));
        if (in_xfer) begin
            if (cnt_q == PH_LAST) begin
                cnt_d = '0;
                if (phase_q == PH_C) begin
                    phase_d  = PH_A;
                    xfer_end = 1'b1;
                end else begin
                    phase_d = phase_q + 2'd1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        case (state_q)
            ST_POWERUP: begin
                if (cnt_q == PU_LAST) begin
                    state_d    = ST_INIT;
                    cnt_d      = '0;
                    phase_d    = PH_A;
                    init_idx_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_INIT: begin
                if (init_idx_q == CLR_WAIT) begin
                    if (cnt_q == CLR_LAST) begin
                        state_d = ST_ADDR_TOP;
                        cnt_d   = '0;
                        phase_d = PH_A;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (xfer_end) begin
                    init_idx_d = init_idx_q + 3'd1;
                end
            end
            ST_ADDR_TOP: begin
                // Both rows are frozen here so a frame never mixes old and new text.
                if ((phase_q == PH_A) && (cnt_q == '0)) begin
                    snap_top_d = row_top;
                    snap_bot_d = row_bottom;
                end
                if (xfer_end) state_d = ST_WRITE_TOP;
            end
            ST_WRITE_TOP: begin
                if (xfer_end) begin
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd15) state_d = ST_ADDR_BOT;
                end
            end
            ST_ADDR_BOT: begin
                if (xfer_end) state_d = ST_WRITE_BOT;
            end
            ST_WRITE_BOT: begin
                if (xfer_end) begin
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd15) state_d = ST_ADDR_TOP;
                end
            end
            default: begin
                state_d = ST_POWERUP;
                cnt_d   = '0;
                phase_d = PH_A;
            end
        endcase

        // Outputs are decoded from the next state and registered, so the bus
        // pins come straight from flops and EN cannot glitch.
        xfer_next = (state_d != ST_POWERUP) &&
                    !((state_d == ST_INIT) && (init_idx_d == CLR_WAIT));
        lcd_en_d  = xfer_next && (phase_d == PH_B);
        lcd_rs_d  = (state_d == ST_WRITE_TOP) || (state_d == ST_WRITE_BOT);

        lcd_data_d = '0;
        case (state_d)
            ST_INIT: begin
                case (init_idx_d)
                    3'd0:    lcd_data_d = 8'h38;
                    3'd1:    lcd_data_d = 8'h0C;
                    3'd2:    lcd_data_d = 8'h06;
                    3'd3:    lcd_data_d = 8'h01;
                    default: lcd_data_d = 8'h00;
                endcase
            end
            ST_ADDR_TOP:  lcd_data_d = 8'h80;
            // Char 0 is the leftmost byte, which sits at the top of the vector.
            ST_WRITE_TOP: lcd_data_d = snap_top_q[{~idx_d, 3'b000} +: 8];
            ST_ADDR_BOT:  lcd_data_d = 8'hC0;
            ST_WRITE_BOT: lcd_data_d = snap_bot_q[{~idx_d, 3'b000} +: 8];
            default:      lcd_data_d = 8'h00;
        endcase

        frame_done_d = (state_d == ST_WRITE_BOT) && (idx_d == 4'd15) &&
                       (phase_d == PH_C) && (cnt_d == PH_LAST);
        init_done_d  = init_done_q || (state_d == ST_ADDR_TOP);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q      <= ST_POWERUP;
            phase_q      <= PH_A;
            cnt_q        <= '0;
            idx_q        <= '0;
            init_idx_q   <= '0;
            snap_top_q   <= '0;
            snap_bot_q   <= '0;
            lcd_en_q     <= 1'b0;
            lcd_rs_q     <= 1'b0;
            lcd_data_q   <= '0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            init_idx_q   <= init_idx_d;
            snap_top_q   <= snap_top_d;
            snap_bot_q   <= snap_bot_d;
            lcd_en_q     <= lcd_en_d;
            lcd_rs_q     <= lcd_rs_d;
            lcd_data_q   <= lcd_data_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign lcd_en     = lcd_en_q;
    assign lcd_rs     = lcd_rs_q;
    assign lcd_rw     = 1'b0;
    assign lcd_data   = lcd_data_q;
    assign init_done  = init_done_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_row_driver.sv
// Directed bench for lcd_row_driver with short timing parameters
// (phase 2, power-up 10, clear 5 cycles). Cycle 0 is the first cycle after
// reset release; outputs are sampled 1 time unit after each falling edge.
module tb_lcd_row_driver;

    logic         clk;
    logic         nRst;
    logic [127:0] row_top;
    logic [127:0] row_bottom;
    logic         lcd_en;
    logic         lcd_rs;
    logic         lcd_rw;
    logic [7:0]   lcd_data;
    logic         init_done;
    logic         frame_done;

    lcd_row_driver #(
        .PHASE_CYCLES   (2),
        .POWERUP_CYCLES (10),
        .CLEAR_CYCLES   (5)
    ) dut (
        .clk        (clk),
        .nRst       (nRst),
        .row_top    (row_top),
        .row_bottom (row_bottom),
        .lcd_en     (lcd_en),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_data   (lcd_data),
        .init_done  (init_done),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int cyc;
    int boot;
    int rw_err, pu_err, stab_err, w_err, fd_err, id_err;
    logic en_prev, fd_prev, init_seen, have_r;
    int r_start;
    logic [7:0] r_data, prev_data1, prev_data2;
    logic r_rs, prev_rs1, prev_rs2;

    int         rise_cyc[$];
    logic [7:0] rise_data[$];
    logic       rise_rs[$];
    int         fd_cyc[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mon_reset();
        en_prev    = 1'b0;
        fd_prev    = 1'b0;
        init_seen  = 1'b0;
        have_r     = 1'b0;
        r_start    = 0;
        prev_data1 = '0;
        prev_data2 = '0;
        prev_rs1   = 1'b0;
        prev_rs2   = 1'b0;
        rise_cyc.delete();
        rise_data.delete();
        rise_rs.delete();
        fd_cyc.delete();
    endtask

    task automatic sample();
        if (lcd_rw !== 1'b0) rw_err++;
        if (cyc <= 9 && lcd_en !== 1'b0) pu_err++;
        if (have_r && cyc > r_start && cyc <= r_start + 3 &&
            (lcd_data !== r_data || lcd_rs !== r_rs)) stab_err++;
        if (lcd_en === 1'b1 && !en_prev) begin
            rise_cyc.push_back(cyc);
            rise_data.push_back(lcd_data);
            rise_rs.push_back(lcd_rs);
            if (prev_data1 !== lcd_data || prev_data2 !== lcd_data ||
                prev_rs1 !== lcd_rs || prev_rs2 !== lcd_rs) stab_err++;
            have_r  = 1'b1;
            r_start = cyc;
            r_data  = lcd_data;
            r_rs    = lcd_rs;
        end
        if (lcd_en === 1'b0 && en_prev && (cyc - r_start) != 2) w_err++;
        if (frame_done === 1'b1) begin
            fd_cyc.push_back(cyc);
            if (fd_prev) fd_err++;
        end
        if (init_seen && init_done !== 1'b1) id_err++;
        if (init_done === 1'b1) init_seen = 1'b1;
        if (boot == 0 && cyc == 76) row_top = {16{8'h41}};
        prev_data2 = prev_data1;
        prev_data1 = lcd_data;
        prev_rs2   = prev_rs1;
        prev_rs1   = lcd_rs;
        en_prev    = lcd_en;
        fd_prev    = frame_done;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        cyc++;
        sample();
    endtask

    task automatic release_reset();
        @(negedge clk);
        nRst = 1'b1;
        #1;
        cyc = 0;
        mon_reset();
        sample();
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_en"},    32'(lcd_en),     32'h0);
        check_eq({pfx, "_rs"},    32'(lcd_rs),     32'h0);
        check_eq({pfx, "_rw"},    32'(lcd_rw),     32'h0);
        check_eq({pfx, "_data"},  32'(lcd_data),   32'h0);
        check_eq({pfx, "_init"},  32'(init_done),  32'h0);
        check_eq({pfx, "_frame"}, 32'(frame_done), 32'h0);
    endtask

    // Expected k-th strobe after boot: four init commands, then 34-transfer frames.
    function automatic void exp_xfer(input int k, output int c, output logic [7:0] d, output logic rs);
        logic [7:0] init_cmds [4];
        int j, f, t;
        init_cmds[0] = 8'h38;
        init_cmds[1] = 8'h0C;
        init_cmds[2] = 8'h06;
        init_cmds[3] = 8'h01;
        if (k < 4) begin
            c  = 12 + 6 * k;
            d  = init_cmds[k];
            rs = 1'b0;
        end else begin
            j = k - 4;
            f = j / 34;
            t = j % 34;
            c = 41 + 204 * f + 6 * t;
            if (t == 0) begin
                d = 8'h80; rs = 1'b0;
            end else if (t <= 16) begin
                d = (f == 0) ? 8'h5F : 8'h41; rs = 1'b1;
            end else if (t == 17) begin
                d = 8'hC0; rs = 1'b0;
            end else begin
                d = 8'(8'h30 + (t - 18)); rs = 1'b1;
            end
        end
    endfunction

    initial begin
        int         ec;
        logic [7:0] ed;
        logic       ers;
        int         nx;

        rw_err = 0; pu_err = 0; stab_err = 0; w_err = 0; fd_err = 0; id_err = 0;
        boot = 0;
        cyc  = 0;
        r_data = '0;
        r_rs   = 1'b0;
        mon_reset();
        nRst    = 1'b0;
        row_top = {16{8'h5F}};
        for (int i = 0; i < 16; i++) row_bottom[8 * (15 - i) +: 8] = 8'(8'h30 + i);

        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("rst");

        release_reset();
        while (cyc < 38) step();
        check_eq("init_done_c38", 32'(init_done), 32'h0);
        step();
        check_eq("init_done_c39", 32'(init_done), 32'h1);
        check_eq("addr_top_data_c39", 32'(lcd_data), 32'h80);
        check_eq("addr_top_en_c39", 32'(lcd_en), 32'h0);
        while (cyc < 652) step();

        check_eq("xfer_count", 32'(rise_cyc.size()), 32'd106);
        nx = (rise_cyc.size() < 106) ? rise_cyc.size() : 106;
        for (int k = 0; k < nx; k++) begin
            exp_xfer(k, ec, ed, ers);
            check_eq($sformatf("xfer%0d_cycle", k), 32'(rise_cyc[k]), 32'(ec));
            check_eq($sformatf("xfer%0d_data", k), 32'(rise_data[k]), 32'(ed));
            check_eq($sformatf("xfer%0d_rs", k), 32'(rise_rs[k]), 32'(ers));
        end

        check_eq("frame_done_count", 32'(fd_cyc.size()), 32'd3);
        for (int i = 0; i < fd_cyc.size() && i < 3; i++)
            check_eq($sformatf("frame_done%0d_cycle", i), 32'(fd_cyc[i]), 32'(242 + 204 * i));
        check_eq("frame_done_width_err", 32'(fd_err), 32'd0);
        check_eq("powerup_en_err", 32'(pu_err), 32'd0);
        check_eq("en_width_err", 32'(w_err), 32'd0);
        check_eq("bus_stability_err", 32'(stab_err), 32'd0);
        check_eq("init_done_sticky_err", 32'(id_err), 32'd0);

        // Frame 3 starts at 651; bottom char 0 strobes during cycles 761-762.
        while (cyc < 761) step();
        check_eq("wbot_en_c761", 32'(lcd_en), 32'h1);
        check_eq("wbot_rs_c761", 32'(lcd_rs), 32'h1);
        check_eq("wbot_data_c761", 32'(lcd_data), 32'h30);
        #1;
        nRst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("midrst_hold");

        boot = 1;
        release_reset();
        while (cyc < 34) step();
        check_eq("reboot_xfer_count", 32'(rise_cyc.size()), 32'd4);
        nx = (rise_cyc.size() < 4) ? rise_cyc.size() : 4;
        for (int k = 0; k < nx; k++) begin
            exp_xfer(k, ec, ed, ers);
            check_eq($sformatf("reboot%0d_cycle", k), 32'(rise_cyc[k]), 32'(ec));
            check_eq($sformatf("reboot%0d_data", k), 32'(rise_data[k]), 32'(ed));
        end
        check_eq("reboot_init_done_c34", 32'(init_done), 32'h0);
        check_eq("reboot_powerup_en_err", 32'(pu_err), 32'd0);
        check_eq("rw_err", 32'(rw_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
